// File: rtl/sid_pkg.sv
// Shared register map, voice configuration layout and bank unpack helpers
// for the SID register front-end.
package sid_pkg;

  localparam int NUM_VOICES = 3;
  localparam int NUM_REGS   = 25;

  localparam logic [4:0] SID_FREQ_LO  = 5'd0;
  localparam logic [4:0] SID_FREQ_HI  = 5'd1;
  localparam logic [4:0] SID_PW_LO    = 5'd2;
  localparam logic [4:0] SID_PW_HI    = 5'd3;
  localparam logic [4:0] SID_CTRL     = 5'd4;
  localparam logic [4:0] SID_AD       = 5'd5;
  localparam logic [4:0] SID_SR       = 5'd6;
  localparam int         SID_VSTRIDE  = 7;
  localparam logic [4:0] SID_FC_LO    = 5'd21;
  localparam logic [4:0] SID_FC_HI    = 5'd22;
  localparam logic [4:0] SID_RES_FILT = 5'd23;
  localparam logic [4:0] SID_MODE_VOL = 5'd24;
  localparam logic [4:0] SID_POTX     = 5'd25;
  localparam logic [4:0] SID_POTY     = 5'd26;
  localparam logic [4:0] SID_OSC3     = 5'd27;
  localparam logic [4:0] SID_ENV3     = 5'd28;

  typedef logic [NUM_REGS-1:0][7:0] sid_bank_t;

  typedef struct packed {
    logic [15:0] freq;
    logic [11:0] pw;
    logic [7:0]  control;
    logic [7:0]  att_dec;
    logic [7:0]  sus_rel;
  } sid_voice_cfg_t;

  // Voice v occupies seven consecutive registers starting at v*7.
  function automatic sid_voice_cfg_t voice_cfg(input sid_bank_t r, input int v);
    sid_voice_cfg_t c;
    int b;
    b         = v * SID_VSTRIDE;
    c.freq    = {r[b + int'(SID_FREQ_HI)], r[b + int'(SID_FREQ_LO)]};
    c.pw      = {r[b + int'(SID_PW_HI)][3:0], r[b + int'(SID_PW_LO)]};
    c.control = r[b + int'(SID_CTRL)];
    c.att_dec = r[b + int'(SID_AD)];
    c.sus_rel = r[b + int'(SID_SR)];
    return c;
  endfunction

  function automatic logic [10:0] filter_fc(input sid_bank_t r);
    return {r[SID_FC_HI], r[SID_FC_LO][2:0]};
  endfunction

endpackage

// File: rtl/sid_bus_latch.sv
// Floating data-bus model: holds the last driven byte and clears it after
// BUS_HOLD ce_1m ticks without a fresh load.
module sid_bus_latch #(
  parameter int BUS_HOLD = 'h2000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ce_1m,
  input  logic       load_i,
  input  logic [7:0] value_i,
  output logic [7:0] value_o
);

  localparam int             CW   = $clog2(BUS_HOLD + 1);
  localparam logic [CW-1:0]  HOLD = CW'(BUS_HOLD);

  logic [7:0]    val_q, val_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A load always wins over a coincident terminal decrement.
  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    if (load_i) begin
      val_d = value_i;
      cnt_d = HOLD;
    end else if (ce_1m && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) val_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign value_o = val_q;

endmodule

// File: rtl/sid_regs.sv
// SID register file: shadow/active banks committed on ce_1m, readback mux
// and the floating bus latch.
module sid_regs
  import sid_pkg::*;
#(
  parameter int BUS_HOLD = 'h2000
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             ce_1m,
  input  logic                             cs,
  input  logic                             we,
  input  logic [4:0]                       addr,
  input  logic [7:0]                       data_in,
  output logic [7:0]                       data_out,
  output logic [NUM_VOICES-1:0][15:0]      freq,
  output logic [NUM_VOICES-1:0][11:0]      pw,
  output logic [NUM_VOICES-1:0][7:0]       control,
  output logic [NUM_VOICES-1:0][7:0]       att_dec,
  output logic [NUM_VOICES-1:0][7:0]       sus_rel,
  output logic [10:0]                      fc,
  output logic [7:0]                       res_filt,
  output logic [7:0]                       mode_vol,
  input  logic [7:0]                       pot_x,
  input  logic [7:0]                       pot_y,
  input  logic [7:0]                       osc3,
  input  logic [7:0]                       env3
);

  sid_bank_t           shadow_q, shadow_d;
  sid_bank_t           active_q, active_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [7:0]          osc3_q, env3_q;
  logic [7:0]          dout_q, dout_d;
  logic [7:0]          latch_val;
  logic [7:0]          rd_val;
  logic                wr, rd, wr_reg, rd_live;

  assign wr      = cs & we;
  assign rd      = cs & ~we;
  assign wr_reg  = wr & (addr <= SID_MODE_VOL);
  assign rd_live = rd & (addr >= SID_POTX) & (addr <= SID_ENV3);

  // Commit uses the pre-write shadow, so a write coincident with ce_1m
  // stays pending until the following strobe.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    if (ce_1m) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (pend_q[i]) active_d[i] = shadow_q[i];
      pend_d = '0;
    end
    if (wr_reg) begin
      shadow_d[addr] = data_in;
      pend_d[addr]   = 1'b1;
    end
  end

  always_comb begin
    case (addr)
      SID_POTX: rd_val = pot_x;
      SID_POTY: rd_val = pot_y;
      SID_OSC3: rd_val = osc3_q;
      SID_ENV3: rd_val = env3_q;
      default:  rd_val = latch_val;
    endcase
    dout_d = rd ? rd_val : dout_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= '0;
      osc3_q   <= '0;
      env3_q   <= '0;
      dout_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      dout_q   <= dout_d;
      if (ce_1m) begin
        osc3_q <= osc3;
        env3_q <= env3;
      end
    end
  end

  sid_bus_latch #(.BUS_HOLD(BUS_HOLD)) u_latch (
    .clock   (clock),
    .reset_n (reset_n),
    .ce_1m   (ce_1m),
    .load_i  (wr | rd_live),
    .value_i (wr ? data_in : rd_val),
    .value_o (latch_val)
  );

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    sid_voice_cfg_t cfg;
    assign cfg        = voice_cfg(active_q, v);
    assign freq[v]    = cfg.freq;
    assign pw[v]      = cfg.pw;
    assign control[v] = cfg.control;
    assign att_dec[v] = cfg.att_dec;
    assign sus_rel[v] = cfg.sus_rel;
  end

  assign fc       = filter_fc(active_q);
  assign res_filt = active_q[SID_RES_FILT];
  assign mode_vol = active_q[SID_MODE_VOL];
  assign data_out = dout_q;

endmodule

// File: tb/tb_sid_regs.sv
// Directed bench for sid_regs: commit atomicity, ce-coincident writes,
// readback snapshots, bus decay/reload and asynchronous reset.
module tb_sid_regs;
  import sid_pkg::*;

  localparam int HOLD = 8;

  logic                        clock = 1'b0;
  logic                        reset_n = 1'b0;
  logic                        ce_1m = 1'b0, cs = 1'b0, we = 1'b0;
  logic [4:0]                  addr = '0;
  logic [7:0]                  data_in = '0;
  logic [7:0]                  data_out;
  logic [NUM_VOICES-1:0][15:0] freq;
  logic [NUM_VOICES-1:0][11:0] pw;
  logic [NUM_VOICES-1:0][7:0]  control, att_dec, sus_rel;
  logic [10:0]                 fc;
  logic [7:0]                  res_filt, mode_vol;
  logic [7:0]                  pot_x = 8'h5C, pot_y = 8'h00, osc3 = 8'h00, env3 = 8'h00;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sid_regs #(.BUS_HOLD(HOLD)) dut (
    .clock(clock), .reset_n(reset_n), .ce_1m(ce_1m), .cs(cs), .we(we),
    .addr(addr), .data_in(data_in), .data_out(data_out),
    .freq(freq), .pw(pw), .control(control), .att_dec(att_dec), .sus_rel(sus_rel),
    .fc(fc), .res_filt(res_filt), .mode_vol(mode_vol),
    .pot_x(pot_x), .pot_y(pot_y), .osc3(osc3), .env3(env3)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      $error("%s mismatch", tag);
    end
  endtask

  task automatic step(input logic c, input logic s, input logic w,
                      input logic [4:0] a, input logic [7:0] d);
    ce_1m = c; cs = s; we = w; addr = a; data_in = d;
    @(posedge clock); #1;
    ce_1m = 1'b0; cs = 1'b0; we = 1'b0;
  endtask

  task automatic strobe();
    step(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    step(1'b0, 1'b1, 1'b0, a, 8'h00);
  endtask

  initial begin
    #22 reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst_data_out", 16'(data_out), 16'h0000);
    check("rst_freq0",    freq[0],       16'h0000);
    check("rst_mode_vol", 16'(mode_vol), 16'h0000);

    // 16-bit frequency written as two bytes appears atomically
    strobe();
    wr(5'd0, 8'h34);
    check("freq0_pending_lo", freq[0], 16'h0000);
    wr(5'd1, 8'h12);
    wr(5'd2, 8'hFF);
    wr(5'd3, 8'hAB);
    check("freq0_pending_hi", freq[0], 16'h0000);
    strobe();
    check("freq0_commit", freq[0],    16'h1234);
    check("pw0_commit",   16'(pw[0]), 16'h0BFF);

    // write coincident with ce_1m waits for the next strobe
    step(1'b1, 1'b1, 1'b1, 5'd4, 8'h41);
    check("ctrl0_same_ce", 16'(control[0]), 16'h0000);
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    strobe();
    check("ctrl0_next_ce", 16'(control[0]), 16'h0041);

    // snapshot readback and latch refresh
    osc3 = 8'hA5; env3 = 8'h3C;
    strobe();
    osc3 = 8'h11; env3 = 8'h22;
    rd(5'd27);
    check("rd_osc3",       16'(data_out), 16'h00A5);
    rd(5'd0);
    check("rd_latch_osc3", 16'(data_out), 16'h00A5);
    rd(5'd28);
    check("rd_env3",       16'(data_out), 16'h003C);
    rd(5'd25);
    check("rd_potx",       16'(data_out), 16'h005C);

    // decay after HOLD strobes
    wr(5'd24, 8'h5A);
    strobe();
    check("mode_vol_5a", 16'(mode_vol), 16'h005A);
    for (int i = 0; i < HOLD - 2; i++) strobe();
    rd(5'd10);
    check("decay_hold_m1", 16'(data_out), 16'h005A);
    strobe();
    rd(5'd10);
    check("decay_hold",    16'(data_out), 16'h0000);

    // load on the terminal-decrement strobe wins; addr 30 only drives the bus
    wr(5'd24, 8'h77);
    for (int i = 0; i < HOLD - 1; i++) strobe();
    step(1'b1, 1'b1, 1'b1, 5'd30, 8'hC3);
    check("term_cnt_reload", 16'(dut.u_latch.cnt_q), 16'(HOLD));
    rd(5'd10);
    check("term_latch_val", 16'(data_out), 16'h00C3);
    check("mode_vol_77",    16'(mode_vol), 16'h0077);

    // asynchronous reset with pending writes
    wr(5'd7, 8'h99);
    strobe();
    check("freq1_commit", freq[1], 16'h0099);
    wr(5'd8, 8'h55);
    wr(5'd23, 8'hF1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_freq1",    freq[1],       16'h0000);
    check("async_rst_data_out", 16'(data_out), 16'h0000);
    check("async_rst_freq0",    freq[0],       16'h0000);
    @(posedge clock); #1;
    reset_n = 1'b1;
    strobe();
    check("post_rst_freq1",    freq[1],       16'h0000);
    check("post_rst_res_filt", 16'(res_filt), 16'h0000);
    rd(5'd10);
    check("post_rst_latch",    16'(data_out), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
